// File: rtl/ascii_to_binary_parser.sv
// ascii_to_binary_parser: converts three ASCII characters (hundreds, tens,
// units) into an 8-bit binary value. Leading spaces are allowed; any other
// non-digit, a space after a digit, an all-blank field, or a value above 255
// flags an error. Fixed latency: done pulses four cycles after the start edge.
module ascii_to_binary_parser (
   input  logic        clk,
   input  logic        rst,
   input  logic        ifStart,
   input  logic [23:0] asciiNum,
   output logic [7:0]  binaryNum,
   output logic        ifDone,
   output logic        ifBusy,
   output logic        ifError
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACC    = 2'd1;
   localparam logic [1:0] S_FINISH = 2'd2;

   logic [1:0]  r_state;
   logic [23:0] r_operand;
   logic [9:0]  r_acc;
   logic [1:0]  r_idx;
   logic        r_seen;
   logic        r_err;
   logic [7:0]  r_bin;
   logic        r_done;
   logic        r_busy;
   logic        r_error;

   logic [7:0]  w_char;
   logic        w_is_digit;
   logic        w_is_space;
   logic [9:0]  w_acc_next;
   logic        w_bad_result;

   // Select the character under the digit index, most significant first.
   always_comb begin
      w_char = r_operand[7:0];
      case (r_idx)
         2'd2:    w_char = r_operand[23:16];
         2'd1:    w_char = r_operand[15:8];
         default: w_char = r_operand[7:0];
      endcase
   end

   // Classify the character; the low nibble of '0'..'9' is the digit value.
   // acc never exceeds 99 before the multiply, so 10 bits never wrap.
   assign w_is_digit   = (w_char >= 8'h30) && (w_char <= 8'h39);
   assign w_is_space   = (w_char == 8'h20);
   assign w_acc_next   = (r_acc * 10'd10) + {6'd0, w_char[3:0]};
   assign w_bad_result = r_err || !r_seen || (r_acc > 10'd255);

   // Control FSM, accumulator and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_operand <= 24'd0;
         r_acc     <= 10'd0;
         r_idx     <= 2'd0;
         r_seen    <= 1'b0;
         r_err     <= 1'b0;
         r_bin     <= 8'h00;
         r_done    <= 1'b0;
         r_busy    <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (ifStart) begin
                  r_operand <= asciiNum;
                  r_acc     <= 10'd0;
                  r_idx     <= 2'd2;
                  r_seen    <= 1'b0;
                  r_err     <= 1'b0;
                  r_busy    <= 1'b1;
                  r_error   <= 1'b0;
                  r_state   <= S_ACC;
               end
            end
            S_ACC: begin
               if (w_is_digit) begin
                  r_acc  <= w_acc_next;
                  r_seen <= 1'b1;
               end else if (!(w_is_space && !r_seen)) begin
                  // Keep stepping through the field so latency stays fixed.
                  r_err <= 1'b1;
               end
               if (r_idx == 2'd0) r_state <= S_FINISH;
               else               r_idx   <= r_idx - 2'd1;
            end
            S_FINISH: begin
               // Result is published on the way out, so done lands one
               // cycle after the last character and start here is ignored.
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_error <= w_bad_result;
               r_bin   <= w_bad_result ? 8'h00 : r_acc[7:0];
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign binaryNum = r_bin;
   assign ifDone    = r_done;
   assign ifBusy    = r_busy;
   assign ifError   = r_error;

endmodule

// File: tb/tb_ascii_to_binary_parser.sv
// Directed bench for ascii_to_binary_parser: timing, result values, error
// rules, start-hold throughput and mid-conversion reset.
module tb_ascii_to_binary_parser;

   logic        clk;
   logic        rst;
   logic        ifStart;
   logic [23:0] asciiNum;
   logic [7:0]  binaryNum;
   logic        ifDone;
   logic        ifBusy;
   logic        ifError;

   int n_chk;
   int n_err;

   ascii_to_binary_parser dut (
      .clk       (clk),
      .rst       (rst),
      .ifStart   (ifStart),
      .asciiNum  (asciiNum),
      .binaryNum (binaryNum),
      .ifDone    (ifDone),
      .ifBusy    (ifBusy),
      .ifError   (ifError)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Step to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One conversion with full latency checks; returns 1 cycle after done.
   task automatic run_conv(input string tag, input logic [23:0] op,
                           input logic [7:0] exp_bin, input logic exp_err);
      asciiNum = op;
      ifStart  = 1'b1;
      step();                          // E0
      ifStart  = 1'b0;
      chk({tag, " busy/done E0"}, {ifBusy, ifDone}, 2'b10);
      for (int e = 1; e <= 3; e++) begin
         step();
         chk($sformatf("%s busy/done E%0d", tag, e), {ifBusy, ifDone}, 2'b10);
      end
      step();                          // E4
      chk({tag, " busy/done E4"}, {ifBusy, ifDone}, 2'b01);
      chk({tag, " bin"}, binaryNum, exp_bin);
      chk({tag, " err"}, ifError, exp_err);
      step();                          // E5: result held, pulse gone
      chk({tag, " hold"}, {ifDone, ifError, binaryNum}, {1'b0, exp_err, exp_bin});
   endtask

   int done_k[$];
   logic [7:0] done_bin[$];

   initial begin
      n_chk    = 0;
      n_err    = 0;
      rst      = 1'b1;
      ifStart  = 1'b1;                 // reset must win over start
      asciiNum = 24'h323535;
      step();
      step();
      chk("reset outs", {ifBusy, ifDone, ifError, binaryNum}, 11'd0);
      rst     = 1'b0;
      ifStart = 1'b0;
      step();

      run_conv("255", 24'h323535, 8'hFF, 1'b0);
      run_conv("__7", 24'h202037, 8'h07, 1'b0);
      run_conv("007", 24'h303037, 8'h07, 1'b0);
      run_conv("256", 24'h323536, 8'h00, 1'b1);
      run_conv("999", 24'h393939, 8'h00, 1'b1);
      run_conv("1_2", 24'h312032, 8'h00, 1'b1);
      run_conv("1A3", 24'h314133, 8'h00, 1'b1);
      run_conv("___", 24'h202020, 8'h00, 1'b1);
      run_conv("100", 24'h313030, 8'h64, 1'b0);
      run_conv("_0_", 24'h203020, 8'h00, 1'b1);

      // Start held 12 cycles; operand disturbed while busy must not matter.
      asciiNum = 24'h313233;
      ifStart  = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         if (ifDone) begin
            done_k.push_back(k);
            done_bin.push_back(binaryNum);
         end
         if (k == 1) asciiNum = 24'h395839;
         if (k == 3) asciiNum = 24'h313233;
      end
      ifStart = 1'b0;
      chk("hold done count", done_k.size(), 2);
      if (done_k.size() == 2) begin
         chk("hold first done", done_k[0], 4);
         chk("hold spacing", done_k[1] - done_k[0], 5);
         chk("hold bin0", done_bin[0], 8'h7B);
         chk("hold bin1", done_bin[1], 8'h7B);
      end
      // Drain the third accepted conversion (bounded wait).
      begin
         int guard;
         guard = 0;
         while (ifBusy && guard < 20) begin
            step();
            guard++;
         end
         chk("drain timeout", ifBusy, 1'b0);
      end
      step();

      // Reset two cycles after start aborts the conversion silently.
      begin
         int saw_done;
         saw_done = 0;
         asciiNum = 24'h323535;
         ifStart  = 1'b1;
         step();                       // E0
         ifStart  = 1'b0;
         step();                       // E1
         rst = 1'b1;
         step();                       // E2 reset
         rst = 1'b0;
         chk("rst outs", {ifBusy, ifDone, ifError, binaryNum}, 11'd0);
         for (int k = 0; k < 6; k++) begin
            step();
            if (ifDone || ifBusy) saw_done++;
         end
         chk("rst no done", saw_done, 0);
      end
      run_conv("042", 24'h303432, 8'h2A, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ascii_to_binary_parser.md
ASCII_TO_BINARY_PARSER -- requirements
Module: ascii_to_binary_parser

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  input  1  rising-edge clock; sole clock.
- rst  input  1  synchronous, active-high reset.
- ifStart  input  1  request to convert; sampled only when ifBusy=0.
- asciiNum  input  24  three ASCII characters, hundreds in [23:16], tens in [15:8], units in [7:0].
- binaryNum  output  8  converted value, registered.
- ifDone  output  1  one-cycle completion pulse.
- ifBusy  output  1  conversion in progress.
- ifError  output  1  result invalid; qualified by ifDone, held until the next accepted start.

REQ-002 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-003 The FSM SHALL have the states IDLE, ACC, FINISH.
REQ-004 IDLE with ifStart=1:
- latch asciiNum into an internal 24-bit register;
- clear the 10-bit accumulator acc, the digit index (set to 2, the hundreds digit), the seenDigit flag and the internal error flag;
- set ifBusy=1, clear ifError;
- go to ACC.
REQ-005 ifStart SHALL be ignored while ifBusy=1; the latched operand is not disturbed.
REQ-006 ACC SHALL process one character per cycle, most significant first, for exactly 3 cycles, then go to FINISH.
REQ-007 Character '0'..'9' (0x30..0x39): acc <= acc*10 + (char-0x30), computed at 10-bit width (max 999, no wrap); seenDigit <= 1.
REQ-008 Character 0x20 (space) before any digit SHALL be a leading blank: acc unchanged.
REQ-009 Space after a digit, or any other byte value, SHALL set the internal error flag.
- Processing continues, so latency stays fixed.
REQ-010 FINISH, for one cycle:
- ifDone=1 and ifBusy=0;
- next state IDLE.
REQ-011 FINISH result rules:
- error flag set, or seenDigit=0 (three blanks), or acc>255: ifError=1 and binaryNum=8'h00;
- otherwise: ifError=0 and binaryNum=acc[7:0].
REQ-012 Fixed latency: start sampled at edge E0 -> ifBusy=1 after E0..E3, ifDone=1 for the single cycle after E4.
REQ-013 ifStart=1 in the FINISH cycle SHALL be ignored.
- Back-to-back throughput is one conversion per 5 cycles; a start is accepted in IDLE on the cycle after ifDone.
REQ-014 binaryNum SHALL hold its last value until the next FINISH.
REQ-015 ifDone SHALL never be high for two consecutive cycles.

Reset
REQ-016 rst=1 at a clock edge SHALL force the following, overriding all other activity including ifStart:
- state=IDLE;
- binaryNum=8'h00, ifDone=0, ifBusy=0, ifError=0;
- acc=0 and internal flags cleared.
REQ-017 Reset during ACC or FINISH SHALL abort the conversion with no ifDone pulse.
- The first ifStart after rst deasserts is accepted normally.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- "255" (0x323535) -> ifDone 4 cycles after the start edge, binaryNum=0xFF, ifError=0.
- "  7" (0x202037) -> binaryNum=0x07, ifError=0; then "007" (0x303037) -> 0x07, ifError=0.
- "256" (0x323536) -> ifError=1, binaryNum=0x00; "999" -> ifError=1.
- "1 2" (0x312032) -> ifError=1; "1A3" -> ifError=1; "   " (0x202020) -> ifError=1.
- ifStart held high for 12 cycles with "123" -> two conversions with ifDone exactly 5 cycles apart, both binaryNum=0x7B, and no operand change mid-conversion.
- rst pulsed 2 cycles after start -> no ifDone, all outputs 0; the next start of "042" -> 0x2A.
